// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM states,
// special-case constants and operand signedness decode.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [MDU_XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [MDU_XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIXUP, DONE} mdu_state_t;

  // MULHU and the unsigned divides treat A as unsigned; MULHSU additionally keeps B unsigned.
  function automatic logic op_signed_a(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1:0] != 2'b11);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f);
    return f[2] ? ~f[0] : ~f[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, purely combinational (zero latency, no flow control).
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu_seq.sv
// RV32M sequencer: 35-cycle bit-serial mul/div (1 cycle for div special cases); stall holds the pipe.
// MDU_MUL_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  mdu_state_t        state, state_nxt;
  logic [2:0]        op;
  logic              sa, sb;
  logic [XLEN-1:0]   acc_hi, acc_lo, opb, mplier;
  logic [CNT_W-1:0]  cnt;

  logic              is_div, is_rem, accept, special;
  logic              div_by0, div_ovf;
  logic [XLEN-1:0]   special_res, abs_a, abs_b, fix_res;
  logic [2*XLEN-1:0] fix_in, fix_out, prod_aligned;
  logic              fix_neg;
  logic [XLEN:0]     op_x, op_y;
  logic [XLEN+1:0]   add_res;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic              q_bit, mul_done_early, load_skip;

  assign is_div = op[2];
  assign is_rem = op[1];
  assign accept = (state == IDLE) && start && !flush;

  assign div_by0 = funct3[2] && (rs2_data == '0);
  assign div_ovf = funct3[2] && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == DIV0_QUOT);
  assign special = div_by0 || div_ovf;
  always_comb begin
    special_res = funct3[1] ? '0 : INT_MIN;
    if (div_by0) special_res = funct3[1] ? rs1_data : DIV0_QUOT;
  end

  // The result-sign negator is idle during LOAD, so it also produces |B| there.
  always_comb begin
    fix_in  = {{XLEN{1'b0}}, opb};
    fix_neg = sb;
    if (state == FIXUP) begin
      if (is_div) begin
        fix_in  = {{XLEN{1'b0}}, is_rem ? acc_hi : acc_lo};
        fix_neg = is_rem ? sa : (sa ^ sb);
      end else begin
        fix_in  = {acc_hi, acc_lo};
        fix_neg = sa ^ sb;
      end
    end
  end

  mdu_sign_fix #(.W(XLEN))   u_abs (.neg(sa),      .din(acc_lo), .dout(abs_a));
  mdu_sign_fix #(.W(2*XLEN)) u_fix (.neg(fix_neg), .din(fix_in), .dout(fix_out));

  assign abs_b   = fix_out[XLEN-1:0];
  assign fix_res = (is_div || op == MDU_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

  // Shared adder: multiply adds the multiplicand, divide trial-subtracts the divisor.
  assign op_x    = is_div ? {acc_hi, acc_lo[XLEN-1]} : {1'b0, acc_hi};
  assign op_y    = (is_div || mplier[0]) ? {1'b0, opb} : '0;
  assign add_res = {1'b0, op_x} + ({1'b0, op_y} ^ {(XLEN+2){is_div}}) + (XLEN+2)'(is_div);
  assign q_bit   = !add_res[XLEN+1];

  always_comb begin
    if (is_div) begin
      hi_nxt = q_bit ? add_res[XLEN-1:0] : op_x[XLEN-1:0];
      lo_nxt = {acc_lo[XLEN-2:0], q_bit};
    end else begin
      hi_nxt = add_res[XLEN:1];
      lo_nxt = {add_res[0], acc_lo[XLEN-1:1]};
    end
  end

`ifdef MDU_MUL_EARLY_OUT_EN
  // The remaining cnt-1 iterations would only shift right, so apply them in one step.
  assign mul_done_early = !is_div && (mplier[XLEN-1:1] == '0);
  assign load_skip      = !is_div && (abs_b == '0);
  assign prod_aligned   = {hi_nxt, lo_nxt} >> (cnt - 1'b1);
`else
  assign mul_done_early = 1'b0;
  assign load_skip      = 1'b0;
  assign prod_aligned   = {hi_nxt, lo_nxt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = special ? DONE : LOAD;
      LOAD:    state_nxt = load_skip ? FIXUP : CALC;
      CALC:    if (cnt == CNT_W'(1) || mul_done_early) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy  = (state == LOAD) || (state == CALC) || (state == FIXUP);
    stall = busy || (start && state == IDLE);
    valid = (state == DONE) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op     <= funct3;
          sa     <= op_signed_a(funct3) && rs1_data[XLEN-1];
          sb     <= op_signed_b(funct3) && rs2_data[XLEN-1];
          acc_hi <= '0;
          acc_lo <= rs1_data;
          opb    <= rs2_data;
          mplier <= '0;
          cnt    <= '0;
          if (special) result <= special_res;
        end
        LOAD: begin
          acc_hi <= '0;
          cnt    <= CNT_W'(XLEN);
          if (is_div) begin
            acc_lo <= abs_a;
            opb    <= abs_b;
          end else begin
            acc_lo <= '0;
            opb    <= abs_a;
            mplier <= abs_b;
          end
        end
        CALC: begin
          cnt              <= cnt - 1'b1;
          mplier           <= mplier >> 1;
          {acc_hi, acc_lo} <= mul_done_early ? prod_aligned : {hi_nxt, lo_nxt};
        end
        FIXUP: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed RV32M vectors, flush, reset and re-sampled start.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        busy, stall, valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .busy(busy), .stall(stall), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from the accepting IDLE cycle to the valid strobe.
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_MUL_EARLY_OUT_EN
    logic [31:0] babs;
`endif
    if (f[2]) begin
      if (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 35;
    end
`ifdef MDU_MUL_EARLY_OUT_EN
    babs = (b[31] && !f[1]) ? -b : b;
    if (babs == 32'h0) return 3;
    for (int i = 31; i >= 0; i--)
      if (babs[i]) return 4 + i;
`endif
    return 35;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: valid with no pending op, result 0x%08h (cycle %0d)", result, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.res);
        check("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Called at a falling edge; start is seen at the next rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat);
    start = 1'b1;
    funct3 = f;
    rs1_data = a;
    rs2_data = b;
    sb_q.push_back('{r, cyc + lat});
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy || valid) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    n_chk++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL wait_idle: timeout with %0d ops pending, busy=%0b", sb_q.size(), busy);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r);
    @(negedge clk);
    issue(f, a, b, r, lat_of(f, a, b));
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int stall_n;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_result", result, 32'h0);

    // MUL 7 * -3, counting cycles with stall high from the accept cycle onward.
    @(negedge clk);
    lat = lat_of(MDU_MUL, 32'd7, 32'hFFFF_FFFD);
    stall_n = 0;
    start = 1'b1;
    funct3 = MDU_MUL;
    rs1_data = 32'd7;
    rs2_data = 32'hFFFF_FFFD;
    sb_q.push_back('{32'hFFFF_FFEB, cyc + lat});
    for (int i = 0; i <= lat; i++) begin
      #1;
      if (stall) stall_n++;
      @(negedge clk);
      start = 1'b0;
      rs1_data = $urandom;
    end
    check("mul_stall_cycles", 32'(stall_n), 32'(lat));
    wait_idle();

    run(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run(MDU_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002);
    run(MDU_MUL,    32'd5,         32'd3,         32'd15);
    run(MDU_MUL,    32'h1234_5678, 32'h0,         32'h0);
    run(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run(MDU_DIVU,   32'd100,       32'h0,         32'hFFFF_FFFF);
    run(MDU_REMU,   32'd100,       32'h0,         32'd100);
    run(MDU_REM,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9);
    run(MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run(MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run(MDU_DIVU,   32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF);
    run(MDU_REMU,   32'hFFFF_FFFF, 32'h10,        32'hF);
    run(MDU_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run(MDU_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(MDU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run(MDU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1);

    // DIV 1000/7 flushed at cycle 10, reissued in the IDLE cycle that follows.
    @(negedge clk);
    start = 1'b1;
    funct3 = MDU_DIV;
    rs1_data = 32'd1000;
    rs2_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_result_kept", result, 32'd1);
    issue(MDU_DIV, 32'd1000, 32'd7, 32'd142, 35);
    wait_idle();

    // start held through DONE: the second op is taken only in the following IDLE cycle.
    @(negedge clk);
    start = 1'b1;
    funct3 = MDU_DIVU;
    rs1_data = 32'd100;
    rs2_data = 32'h0;
    sb_q.push_back('{32'hFFFF_FFFF, cyc + 1});
    sb_q.push_back('{32'd100, cyc + 3});
    #1;
    check("stall_on_accept", 32'(stall), 32'h1);
    @(negedge clk);
    #1;
    check("stall_in_done", 32'(stall), 32'h0);
    funct3 = MDU_REMU;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    issue(MDU_DIVU, 32'd1000, 32'd7, 32'd142, 35);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    sb_q.delete();
    @(negedge clk);
    check("arst_result", result, 32'h0);
    rst_n = 1'b1;
    run(MDU_DIVU, 32'd1000, 32'd7, 32'd142);

    check("queue_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting beside the single-cycle integer ALU in EX.
- Accepts operands from the register-read stage and iterates a shared 33-bit add/sub datapath one bit per cycle.
- Holds the pipeline via `stall` and presents a one-cycle `valid` with the 32-bit result for writeback.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk input 1: single clock, rising edge.
- rst_n input 1: reset, asynchronous, active-low.
- start input 1: issue request; sampled only in IDLE.
- funct3 input 3: RV32M op; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data input XLEN: operand A (multiplicand/dividend).
- rs2_data input XLEN: operand B (multiplier/divisor).
- flush input 1: abort in-flight op (branch mispredict/trap).
- busy output 1: high in LOAD/CALC/FIXUP.
- stall output 1: busy | (start & state==IDLE), combinational.
- valid output 1: one-cycle result strobe.
- result output XLEN: result, held stable until next accept.

Behaviour:
- Reset: state=IDLE; busy=0, valid=0, result=0; counter and internal registers cleared.
- States and transitions:
  - IDLE: start=1 latches funct3, operands and sign flags. Then → LOAD, or → DONE for a special case.
  - LOAD: takes absolute values of signed operands; counter=XLEN → CALC.
  - CALC: one iteration per cycle; counter decrements; at 0 → FIXUP.
  - FIXUP: conditional negation, result select → DONE.
  - DONE: valid=1 for exactly one cycle → IDLE.
- Latency: start sampled at cycle 0, valid at cycle 35 (1 LOAD + 32 CALC + 1 FIXUP + DONE). Special cases give valid at cycle 1.
- Multiply:
  - Shift-add on unsigned magnitudes into a 64-bit product.
  - Product sign = sA^sB, where sA = signed op & rs1[31] and sB = signed-B op & rs2[31]. MULHSU treats B as unsigned.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide:
  - Restoring division, 33-bit subtract per cycle.
  - Quotient sign = sA^sB; remainder sign = sA.
- Special cases, detected in IDLE (no CALC):
  - Divisor==0: quotient=0xFFFFFFFF, remainder=rs1.
  - Signed DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Arithmetic wraps modulo 2^XLEN; no exceptions raised.
- Concurrent events:
  - start while busy or in DONE is ignored. The pipeline keeps start asserted while stalled, so it is re-sampled in IDLE.
  - flush in any state → IDLE next edge; valid suppressed; result unchanged. flush has priority over start in the same cycle.
  - Async reset mid-operation → IDLE immediately; no valid.
- Operand inputs may change after accept without affecting the result.

Optional Feature:
- Macro: MDU_MUL_EARLY_OUT_EN.
- Defined: in CALC for multiplies, when the remaining shifted multiplier bits are all zero, the product register is shifted into final alignment and the block jumps to FIXUP.
  - Latency becomes 3 + (index of highest set bit of |B| + 1) cycles.
  - |B|==0 → FIXUP after LOAD.
  - Divides are unaffected.
- Undefined: fixed latency as above; no zero-detect logic.

Decomposition:
- Package mdu_pkg holds:
  - funct3 localparams (MDU_MUL … MDU_REMU).
  - State encoding (IDLE, LOAD, CALC, FIXUP, DONE).
  - XLEN default.
  - Constants: DIV0_QUOT=0xFFFFFFFF, INT_MIN=0x80000000.
- One sub-module, mdu_sign_fix: combinational conditional two's-complement negate used in LOAD (abs) and FIXUP (result sign), instantiated twice.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → stall high cycles 0–34; valid at cycle 35 only; result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → valid at cycle 1, result 0x80000000. REM same operands → 0.
- DIVU 100/0 → 0xFFFFFFFF at cycle 1. REMU 100/0 → 100. REM 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFF. DIV same → 0xFFFFFFFD.
- DIV 1000/7 with flush at cycle 10 → no valid; IDLE at cycle 11; result retains prior value. Reissue → 142 (0x8E) at cycle 46.
- Reset asserted mid-CALC → busy=0 and valid=0 immediately. start held during DONE is not accepted until the following IDLE cycle. With MDU_MUL_EARLY_OUT_EN, MUL 5×3 → valid at cycle 5, result 15.
